aes_dec_key_expand: RTL



---
 rtl/aes_dec_pkg.sv | 47 ++++
 rtl/aes_dec_key_expand_if.sv | 15 +
 rtl/aes_sbox.sv | 27 ++
 rtl/aes_dec_key_expand.sv | 102 ++++++++++
 4 files changed

// File: rtl/aes_dec_pkg.sv
// Shared AES decrypt-path definitions: sizes, key-expansion states, GF(2^8) helpers.
package aes_dec_pkg;

  localparam int NR = 10;
  localparam int KW = 128;

  typedef enum logic {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } kx_state_t;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a [4];
    logic [7:0]   x2 [4];
    logic [7:0]   x4 [4];
    logic [7:0]   x8 [4];
    logic [7:0]   m9 [4];
    logic [7:0]   mb [4];
    logic [7:0]   md [4];
    logic [7:0]   me [4];
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) begin
        a[j]  = s[127 - 32*c - 8*j -: 8];
        x2[j] = xtime(a[j]);
        x4[j] = xtime(x2[j]);
        x8[j] = xtime(x4[j]);
        m9[j] = x8[j] ^ a[j];
        mb[j] = x8[j] ^ x2[j] ^ a[j];
        md[j] = x8[j] ^ x4[j] ^ a[j];
        me[j] = x8[j] ^ x4[j] ^ x2[j];
      end
      r[127 - 32*c      -: 8] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
      r[127 - 32*c - 8  -: 8] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
      r[127 - 32*c - 16 -: 8] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
      r[127 - 32*c - 24 -: 8] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_dec_key_expand_if.sv
// Key load and round-key read bus between the register front end / inverse cipher and the key expander.
interface aes_dec_key_expand_if #(parameter int KW = 128);
  logic [KW-1:0] key_in;
  logic          key_valid;
  logic          key_ready;
  logic          busy;
  logic          keys_ready;
  logic [3:0]    rk_addr;
  logic [KW-1:0] rk_data;

  modport master (output key_in, key_valid, rk_addr,
                  input  key_ready, busy, keys_ready, rk_data);
  modport slave  (input  key_in, key_valid, rk_addr,
                  output key_ready, busy, keys_ready, rk_data);
endinterface

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box (one byte).
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  // Listed from entry 0x00 onward; entry 0 sits at the top of the packed vector
  localparam logic [255:0][7:0] SBOX = {
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  assign y = SBOX[~a];
endmodule

// File: rtl/aes_dec_key_expand.sv
// Iterative AES-128 key schedule filling an 11-entry round-key file, one key per clock.
// Define AES_DEC_EQINV_KEY_EN to store RK1..RK9 in equivalent-inverse-cipher form.
module aes_dec_key_expand
  import aes_dec_pkg::*;
#(
  parameter int NR = aes_dec_pkg::NR,
  parameter int KW = aes_dec_pkg::KW
) (
  input logic                 clock,
  input logic                 reset,
  aes_dec_key_expand_if.slave kx
);
  localparam logic [3:0] LAST = 4'(NR);

  kx_state_t     state, state_nx;
  logic [KW-1:0] rk [0:NR];
  logic [KW-1:0] w, w_nx, wr_val, rk_data_q;
  logic [3:0]    rnd, wr_idx;
  logic [7:0]    rcon;
  logic [31:0]   rot, sub, t, w0, w1, w2, w3;
  logic          accept, wr_en, keys_ready_q;

  assign rot = {w[23:0], w[31:24]};
  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (.a(rot[8*i +: 8]), .y(sub[8*i +: 8]));
  end

  assign t    = sub ^ {rcon, 24'h0};
  assign w0   = w[127:96] ^ t;
  assign w1   = w[95:64]  ^ w0;
  assign w2   = w[63:32]  ^ w1;
  assign w3   = w[31:0]   ^ w2;
  assign w_nx = {w0, w1, w2, w3};

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    wr_en    = 1'b0;
    wr_idx   = rnd;
    wr_val   = w_nx;
    case (state)
      IDLE: begin
        if (kx.key_valid) begin
          accept   = 1'b1;
          wr_en    = 1'b1;
          wr_idx   = 4'd0;
          wr_val   = kx.key_in;
          state_nx = EXPAND;
        end
      end
      EXPAND: begin
        wr_en = 1'b1;
`ifdef AES_DEC_EQINV_KEY_EN
        // W keeps the raw key; only the stored middle round keys are transformed
        if (rnd != LAST) wr_val = inv_mix_columns(w_nx);
`else
        wr_val = w_nx;
`endif
        if (rnd == LAST) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      w            <= '0;
      rnd          <= '0;
      rcon         <= 8'h01;
      keys_ready_q <= 1'b0;
      rk_data_q    <= '0;
      for (int i = 0; i <= NR; i++) rk[i] <= '0;
    end else begin
      if (wr_en) rk[wr_idx] <= wr_val;
      if (accept) begin
        w            <= kx.key_in;
        rnd          <= 4'd1;
        rcon         <= 8'h01;
        keys_ready_q <= 1'b0;
      end else if (state == EXPAND) begin
        w    <= w_nx;
        rnd  <= rnd + 4'd1;
        rcon <= xtime(rcon);
        if (rnd == LAST) keys_ready_q <= 1'b1;
      end
      // Write-through so a read of the entry being written returns the new key
      if (kx.rk_addr > LAST)                  rk_data_q <= '0;
      else if (wr_en && wr_idx == kx.rk_addr) rk_data_q <= wr_val;
      else                                    rk_data_q <= rk[kx.rk_addr];
    end
  end

  assign kx.key_ready  = (state == IDLE);
  assign kx.busy       = (state == EXPAND);
  assign kx.keys_ready = keys_ready_q;
  assign kx.rk_data    = rk_data_q;
endmodule
